frame_capture_writer: RTL and testbench

- Write side of the sample frame buffer. The read side is a free-running address counter that cycles through addresses 0..600.
- Captures one frame of DEPTH ADC samples from a valid-qualified stream into a single-write-port RAM at addresses 0..DEPTH-1.
- Start is gated by an arm/trigger sequence. Completion is reported with a frame_ready/frame_ack handshake, so the read side only consumes complete frames.
- Sits between the ADC interface and the frame RAM.

---
 rtl/frame_buf_pkg.sv | 21 ++
 rtl/frame_capture_writer_decim.sv | 52 +++++
 rtl/frame_capture_writer.sv | 187 ++++++++++++++++++
 tb/tb_frame_capture_writer.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/frame_buf_pkg.sv
// Shared definitions for the sample frame buffer: geometry common to the
// writer and the read-side address counter, plus the capture state encoding.
package frame_buf_pkg;

   localparam int FRAME_DEPTH  = 601;
   localparam int FRAME_ADDR_W = 10;
   localparam int SAMPLE_W     = 12;
   localparam int DCNT_W       = 8;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      CAPTURE = 2'd2,
      DONE    = 2'd3
   } cap_state_t;

   function automatic logic state_busy(input cap_state_t s);
      return (s == ARMED) || (s == CAPTURE);
   endfunction

endpackage

// File: rtl/frame_capture_writer_decim.sv
// Valid-sample decimation counter: counts valid samples modulo DECIM and
// flags the samples that are kept (count of zero).
module frame_capture_writer_decim
   import frame_buf_pkg::*;
#(
   parameter int DECIM = 1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic load_valid,
   input  logic step,
   output logic keep
);

   localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(DECIM - 1);

   logic [DCNT_W-1:0] dcnt_r;
   logic [DCNT_W-1:0] dcnt_nxt_s;

   // The trig-cycle sample (load_valid) is counted as the first kept one.
   always_comb begin
      dcnt_nxt_s = dcnt_r;
      if (load) begin
         if (load_valid && (DCNT_LAST != {DCNT_W{1'b0}})) begin
            dcnt_nxt_s = {{(DCNT_W-1){1'b0}}, 1'b1};
         end else begin
            dcnt_nxt_s = {DCNT_W{1'b0}};
         end
      end else if (step) begin
         if (dcnt_r == DCNT_LAST) begin
            dcnt_nxt_s = {DCNT_W{1'b0}};
         end else begin
            dcnt_nxt_s = dcnt_r + {{(DCNT_W-1){1'b0}}, 1'b1};
         end
      end else begin
         dcnt_nxt_s = dcnt_r;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dcnt_r <= {DCNT_W{1'b0}};
      end else begin
         dcnt_r <= dcnt_nxt_s;
      end
   end

   assign keep = (dcnt_r == {DCNT_W{1'b0}});

endmodule

// File: rtl/frame_capture_writer.sv
// Write side of the sample frame buffer: arm/trigger-gated capture of one
// frame of decimated samples into RAM, released through frame_ready/frame_ack.
module frame_capture_writer
   import frame_buf_pkg::*;
#(
   parameter int DATA_W     = SAMPLE_W,
   parameter int DEPTH      = FRAME_DEPTH,
   parameter int ADDR_W     = FRAME_ADDR_W,
   parameter int DECIM      = 1,
   parameter bit AUTO_REARM = 1'b0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              arm,
   input  logic              abort,
   input  logic              trig,
   input  logic              s_valid,
   input  logic [DATA_W-1:0] s_data,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [DATA_W-1:0] wr_data,
   output logic              frame_ready,
   input  logic              frame_ack,
   output logic              busy,
   output logic              overrun
);

   localparam logic [ADDR_W-1:0] ACNT_LAST = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W-1:0] ACNT_ONE  = ADDR_W'(1);

   cap_state_t        state_r;
   cap_state_t        state_nxt_s;
   logic [ADDR_W-1:0] acnt_r;
   logic [ADDR_W-1:0] acnt_nxt_s;
   logic [ADDR_W-1:0] acnt_cur_s;
   logic              start_s;
   logic              keep_s;
   logic              accept_s;
   logic              last_s;

   logic              wr_en_r;
   logic [ADDR_W-1:0] wr_addr_r;
   logic [DATA_W-1:0] wr_data_r;
   logic              frame_ready_r;
   logic              busy_r;
   logic              overrun_r;

   logic              wr_en_nxt_s;
   logic [ADDR_W-1:0] wr_addr_nxt_s;
   logic [DATA_W-1:0] wr_data_nxt_s;
   logic              frame_ready_nxt_s;
   logic              busy_nxt_s;
   logic              overrun_nxt_s;

   frame_capture_writer_decim #(
      .DECIM (DECIM)
   ) u_decim (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (start_s),
      .load_valid (s_valid),
      .step       ((state_r == CAPTURE) && s_valid),
      .keep       (keep_s)
   );

   // Acceptance: the trig cycle behaves as CAPTURE with both counters at zero,
   // since acnt may still hold a stale value from an aborted frame.
   always_comb begin
      start_s    = (state_r == ARMED) && trig && !abort;
      acnt_cur_s = (state_r == ARMED) ? {ADDR_W{1'b0}} : acnt_r;
      if (abort) begin
         accept_s = 1'b0;
      end else if (state_r == ARMED) begin
         accept_s = trig && s_valid;
      end else if (state_r == CAPTURE) begin
         accept_s = s_valid && keep_s;
      end else begin
         accept_s = 1'b0;
      end
      last_s = accept_s && (acnt_cur_s == ACNT_LAST);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; abort overrides every other request.
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (arm) begin
                  state_nxt_s = ARMED;
               end else begin
                  state_nxt_s = IDLE;
               end
            end
            ARMED: begin
               if (trig) begin
                  state_nxt_s = last_s ? DONE : CAPTURE;
               end else begin
                  state_nxt_s = ARMED;
               end
            end
            CAPTURE: begin
               if (last_s) begin
                  state_nxt_s = DONE;
               end else begin
                  state_nxt_s = CAPTURE;
               end
            end
            DONE: begin
               if (frame_ack) begin
                  state_nxt_s = AUTO_REARM ? ARMED : IDLE;
               end else begin
                  state_nxt_s = DONE;
               end
            end
            default: state_nxt_s = IDLE;
         endcase
      end
   end

   // Output and counter next values.
   always_comb begin
      acnt_nxt_s = acnt_r;
      if (start_s) begin
         acnt_nxt_s = (accept_s && !last_s) ? ACNT_ONE : {ADDR_W{1'b0}};
      end else if (accept_s && !last_s) begin
         acnt_nxt_s = acnt_r + ACNT_ONE;
      end else begin
         acnt_nxt_s = acnt_r;
      end

      wr_en_nxt_s   = accept_s;
      wr_addr_nxt_s = accept_s ? acnt_cur_s : wr_addr_r;
      wr_data_nxt_s = accept_s ? s_data : wr_data_r;

      frame_ready_nxt_s = (state_r == DONE) && (state_nxt_s == DONE);
      busy_nxt_s        = state_busy(state_nxt_s);

      if ((state_r == IDLE) && (state_nxt_s == ARMED)) begin
         overrun_nxt_s = 1'b0;
      end else if ((state_r == DONE) && s_valid) begin
         overrun_nxt_s = 1'b1;
      end else begin
         overrun_nxt_s = overrun_r;
      end
   end

   // Registered outputs and address counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acnt_r        <= {ADDR_W{1'b0}};
         wr_en_r       <= 1'b0;
         wr_addr_r     <= {ADDR_W{1'b0}};
         wr_data_r     <= {DATA_W{1'b0}};
         frame_ready_r <= 1'b0;
         busy_r        <= 1'b0;
         overrun_r     <= 1'b0;
      end else begin
         acnt_r        <= acnt_nxt_s;
         wr_en_r       <= wr_en_nxt_s;
         wr_addr_r     <= wr_addr_nxt_s;
         wr_data_r     <= wr_data_nxt_s;
         frame_ready_r <= frame_ready_nxt_s;
         busy_r        <= busy_nxt_s;
         overrun_r     <= overrun_nxt_s;
      end
   end

   assign wr_en       = wr_en_r;
   assign wr_addr     = wr_addr_r;
   assign wr_data     = wr_data_r;
   assign frame_ready = frame_ready_r;
   assign busy        = busy_r;
   assign overrun     = overrun_r;

endmodule

// File: tb/tb_frame_capture_writer.sv
// Directed bench for frame_capture_writer: default, DECIM=3 and AUTO_REARM=1
// instances share one stimulus stream; each phase checks the relevant one.
module tb_frame_capture_writer;
   import frame_buf_pkg::*;

   logic                clk = 1'b0;
   logic                rst_n;
   logic                arm, abort, trig, s_valid, frame_ack;
   logic [SAMPLE_W-1:0] s_data;

   logic                    wr_en_0, wr_en_d, wr_en_a;
   logic [FRAME_ADDR_W-1:0] wr_addr_0, wr_addr_d, wr_addr_a;
   logic [SAMPLE_W-1:0]     wr_data_0, wr_data_d, wr_data_a;
   logic                    ready_0, ready_d, ready_a;
   logic                    busy_0, busy_d, busy_a;
   logic                    ovr_0, ovr_d, ovr_a;

   int errors = 0;
   int checks = 0;
   int nw;

   always #5 clk = ~clk;

   frame_capture_writer dut_0 (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
      .s_valid(s_valid), .s_data(s_data), .wr_en(wr_en_0), .wr_addr(wr_addr_0),
      .wr_data(wr_data_0), .frame_ready(ready_0), .frame_ack(frame_ack),
      .busy(busy_0), .overrun(ovr_0));

   frame_capture_writer #(.DECIM(3)) dut_d (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
      .s_valid(s_valid), .s_data(s_data), .wr_en(wr_en_d), .wr_addr(wr_addr_d),
      .wr_data(wr_data_d), .frame_ready(ready_d), .frame_ack(frame_ack),
      .busy(busy_d), .overrun(ovr_d));

   frame_capture_writer #(.AUTO_REARM(1'b1)) dut_a (
      .clk(clk), .rst_n(rst_n), .arm(arm), .abort(abort), .trig(trig),
      .s_valid(s_valid), .s_data(s_data), .wr_en(wr_en_a), .wr_addr(wr_addr_a),
      .wr_data(wr_data_a), .frame_ready(ready_a), .frame_ack(frame_ack),
      .busy(busy_a), .overrun(ovr_a));

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   initial begin
      rst_n = 1'b0; arm = 1'b0; abort = 1'b0; trig = 1'b0;
      s_valid = 1'b0; frame_ack = 1'b0; s_data = 12'h000;
      repeat (2) @(posedge clk);
      #3;
      chk("rst_wr_en", 32'(wr_en_0), 32'd0);
      chk("rst_wr_addr", 32'(wr_addr_0), 32'd0);
      chk("rst_wr_data", 32'(wr_data_0), 32'd0);
      chk("rst_ready", 32'(ready_0), 32'd0);
      chk("rst_busy", 32'(busy_0), 32'd0);
      chk("rst_overrun", 32'(ovr_0), 32'd0);
      rst_n = 1'b1;
      step();

      // Phase 1: full frame, DECIM=1
      arm = 1'b1; step(); arm = 1'b0;
      chk("p1_busy_armed", 32'(busy_0), 32'd1);
      trig = 1'b1; step(); trig = 1'b0;
      chk("p1_no_write_trig", 32'(wr_en_0), 32'd0);
      for (int i = 0; i < 601; i++) begin
         s_valid = 1'b1; s_data = 12'(i + 256);
         step();
         chk("p1_wr_en", 32'(wr_en_0), 32'd1);
         chk("p1_wr_addr", 32'(wr_addr_0), 32'(i));
         chk("p1_wr_data", 32'(wr_data_0), 32'(i + 256));
      end
      s_valid = 1'b0;
      chk("p1_ready_not_yet", 32'(ready_0), 32'd0);
      chk("p1_last_data", 32'(wr_data_0), 32'h358);
      step();
      chk("p1_ready", 32'(ready_0), 32'd1);
      chk("p1_wr_en_off", 32'(wr_en_0), 32'd0);
      chk("p1_busy_done", 32'(busy_0), 32'd0);

      // Overrun in DONE
      s_valid = 1'b1; s_data = 12'hABC; step(); s_valid = 1'b0;
      chk("ovr_no_write", 32'(wr_en_0), 32'd0);
      chk("ovr_set", 32'(ovr_0), 32'd1);
      chk("ovr_ready_held", 32'(ready_0), 32'd1);
      frame_ack = 1'b1; step(); frame_ack = 1'b0;
      chk("ack_ready_low", 32'(ready_0), 32'd0);
      chk("ack_busy_low", 32'(busy_0), 32'd0);
      chk("ovr_sticky", 32'(ovr_0), 32'd1);
      arm = 1'b1; step(); arm = 1'b0;
      chk("ovr_cleared_by_arm", 32'(ovr_0), 32'd0);
      chk("rearm_busy", 32'(busy_0), 32'd1);

      // Abort at acnt=300
      trig = 1'b1; step(); trig = 1'b0;
      for (int i = 0; i < 300; i++) begin
         s_valid = 1'b1; s_data = 12'(i);
         step();
      end
      chk("abort_inflight_en", 32'(wr_en_0), 32'd1);
      chk("abort_inflight_addr", 32'(wr_addr_0), 32'd299);
      abort = 1'b1; s_data = 12'h12C; step(); abort = 1'b0;
      chk("abort_wr_en", 32'(wr_en_0), 32'd0);
      chk("abort_busy", 32'(busy_0), 32'd0);
      chk("abort_ready", 32'(ready_0), 32'd0);
      nw = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         nw += int'(wr_en_0);
      end
      s_valid = 1'b0;
      chk("abort_no_writes", 32'(nw), 32'd0);
      chk("abort_ready_stays", 32'(ready_0), 32'd0);
      arm = 1'b1; step(); arm = 1'b0;
      trig = 1'b1; s_valid = 1'b1; s_data = 12'h0AB; step();
      trig = 1'b0; s_valid = 1'b0;
      chk("rearm_wr_en", 32'(wr_en_0), 32'd1);
      chk("rearm_addr0", 32'(wr_addr_0), 32'd0);
      chk("rearm_data", 32'(wr_data_0), 32'h0AB);
      abort = 1'b1; step(); abort = 1'b0;

      // Phase 2: DECIM=3, trig-cycle sample captured
      arm = 1'b1; step(); arm = 1'b0;
      nw = 0;
      for (int v = 0; v < 1801; v++) begin
         s_valid = 1'b1; s_data = 12'(v); trig = (v == 0);
         step();
         nw += int'(wr_en_d);
         chk("d3_wr_en", 32'(wr_en_d), (v % 3 == 0) ? 32'd1 : 32'd0);
         if (v % 3 == 0) begin
            chk("d3_wr_addr", 32'(wr_addr_d), 32'(v / 3));
            chk("d3_wr_data", 32'(wr_data_d), 32'(v));
         end
      end
      s_valid = 1'b0; trig = 1'b0;
      chk("d3_write_count", 32'(nw), 32'd601);
      step();
      chk("d3_ready", 32'(ready_d), 32'd1);
      frame_ack = 1'b1; step(); frame_ack = 1'b0;
      chk("d3_ack_ready", 32'(ready_d), 32'd0);
      chk("d3_ack_busy", 32'(busy_d), 32'd0);
      abort = 1'b1; step(); abort = 1'b0;

      // Phase 3: AUTO_REARM, arm ignored during CAPTURE
      arm = 1'b1; step(); arm = 1'b0;
      trig = 1'b1; step(); trig = 1'b0;
      for (int i = 0; i < 601; i++) begin
         s_valid = 1'b1; s_data = 12'(i + 1024); arm = (i == 100) || (i == 200);
         step();
         chk("ar_wr_addr", 32'(wr_addr_a), 32'(i));
         chk("ar_wr_en", 32'(wr_en_a), 32'd1);
      end
      s_valid = 1'b0; arm = 1'b0;
      step();
      chk("ar_ready", 32'(ready_a), 32'd1);
      frame_ack = 1'b1; step(); frame_ack = 1'b0;
      chk("ar_ack_ready", 32'(ready_a), 32'd0);
      chk("ar_busy_rearmed", 32'(busy_a), 32'd1);
      trig = 1'b1; s_valid = 1'b1; s_data = 12'h03C; step();
      trig = 1'b0; s_valid = 1'b0;
      chk("ar_new_wr_en", 32'(wr_en_a), 32'd1);
      chk("ar_new_addr0", 32'(wr_addr_a), 32'd0);
      chk("ar_new_data", 32'(wr_data_a), 32'h03C);
      abort = 1'b1; step(); abort = 1'b0;

      // Phase 4: async reset at acnt=450
      arm = 1'b1; step(); arm = 1'b0;
      trig = 1'b1; step(); trig = 1'b0;
      for (int i = 0; i < 450; i++) begin
         s_valid = 1'b1; s_data = 12'(i + 7);
         step();
      end
      chk("pre_rst_addr", 32'(wr_addr_0), 32'd449);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_wr_en", 32'(wr_en_0), 32'd0);
      chk("arst_wr_addr", 32'(wr_addr_0), 32'd0);
      chk("arst_wr_data", 32'(wr_data_0), 32'd0);
      chk("arst_busy", 32'(busy_0), 32'd0);
      chk("arst_ready", 32'(ready_0), 32'd0);
      chk("arst_overrun", 32'(ovr_0), 32'd0);
      #2 rst_n = 1'b1;
      trig = 1'b1; s_valid = 1'b1;
      nw = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         nw += int'(wr_en_0) + int'(busy_0);
      end
      chk("post_rst_trig_ignored", 32'(nw), 32'd0);
      trig = 1'b0; s_valid = 1'b0;
      arm = 1'b1; step(); arm = 1'b0;
      trig = 1'b1; s_valid = 1'b1; s_data = 12'h055; step();
      trig = 1'b0; s_valid = 1'b0;
      chk("post_rst_capture_en", 32'(wr_en_0), 32'd1);
      chk("post_rst_capture_addr", 32'(wr_addr_0), 32'd0);
      chk("post_rst_ready", 32'(ready_0), 32'd0);
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
